// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file with scoreboard.
// Master drives write/scoreboard/read addresses; slave returns read data.
interface regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                    we;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic                    sb_set;
    logic [AW-1:0]           sb_addr;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic                    init_done;

    modport master (
        output we, wr_addr, wr_data,
        output sb_set, sb_addr, rd_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  we, wr_addr, wr_data,
        input  sb_set, sb_addr, rd_addr,
        output rd_data, rd_busy, init_done
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear FSM and busy scoreboard.
// Optional macro REGFILE_MP_BYPASS_EN adds same-cycle write-through bypass.
module regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              ready;

    logic [NUM_RD*WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]       rbusy;
    logic [AW-1:0]           ra;

    assign ready         = (state_q == READY);
    assign bus.init_done = ready;
    assign bus.rd_data   = rdata;
    assign bus.rd_busy   = rbusy;

    // Clear sequencer: walk every index once, then stay in READY.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1))
                    state_d = READY;
            end
            READY: ;
            default: state_d = CLEAR;
        endcase
    end

    // FSM state and clear index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage has no reset; the clear sequence zeroes it after reset.
    always_ff @(posedge clk) begin
        if (!ready)
            mem_q[idx_q] <= '0;
        else if (bus.we && bus.wr_addr != '0)
            mem_q[bus.wr_addr] <= bus.wr_data;
    end

    // Scoreboard next state: write clears, set wins, r0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            if (bus.we)
                busy_d[bus.wr_addr] = 1'b0;
            if (bus.sb_set)
                busy_d[bus.sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // Combinational read ports; everything reads zero until READY.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (ready) begin
                if (ra != '0)
                    rdata[i*WIDTH +: WIDTH] = mem_q[ra];
                rbusy[i] = busy_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
                if (bus.we && bus.wr_addr != '0 && ra == bus.wr_addr) begin
                    rdata[i*WIDTH +: WIDTH] = bus.wr_data;
                    rbusy[i] = bus.sb_set && (bus.sb_addr == ra);
                end
`else
                rbusy[i] = busy_q[ra];
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default build plus a 4-port 64x16 copy.
// Expected values go through a scoreboard queue and are popped at sampling.
module tb_regfile_mp;
    logic clk;
    logic rst_n;

    int pass_cnt;
    int tot_cnt;
    logic [63:0] exp_q [$];
    logic [63:0] got;
    logic [63:0] e;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.WIDTH(64), .DEPTH(16), .NUM_RD(4)) ifb ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    regfile_mp #(.WIDTH(64), .DEPTH(16), .NUM_RD(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.rd_addr = {5'd5, 5'd0};
        #12;
        exp_q.push_back(64'd0);
        got = 64'(ifa.init_done);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL reset_init_done got=%h exp=%h", got, e);
        else pass_cnt++;
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_data);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL reset_rd_data got=%h exp=%h", got, e);
        else pass_cnt++;
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_busy);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL reset_rd_busy got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            ifa.we      = 1'b1;
            ifa.wr_addr = 5'(k);
            ifa.wr_data = 32'hFFFF_0000 | 32'(k);
            ifa.sb_set  = 1'b1;
            ifa.sb_addr = 5'(k);
            step();
            exp_q.push_back(64'(k >= 32));
            got = 64'(ifa.init_done);
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL clear_init_done_a k=%0d got=%h exp=%h", k, got, e);
            else pass_cnt++;
            exp_q.push_back(64'(k >= 16));
            got = 64'(ifb.init_done);
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL clear_init_done_b k=%0d got=%h exp=%h", k, got, e);
            else pass_cnt++;
            if (k < 32) begin
                exp_q.push_back(64'd0);
                got = 64'(ifa.rd_data) | 64'(ifa.rd_busy);
                e = exp_q.pop_front();
                tot_cnt++;
                if (got !== e) $display("FAIL clear_reads_zero k=%0d got=%h exp=%h", k, got, e);
                else pass_cnt++;
            end
        end
        ifa.we     = 1'b0;
        ifa.sb_set = 1'b0;
        for (int a = 1; a < 32; a++) begin
            ifa.rd_addr = {5'(a), 5'(a)};
            #1;
            exp_q.push_back(64'd0);
            exp_q.push_back(64'd0);
            got = 64'(ifa.rd_data);
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL clear_mem_zero a=%0d got=%h exp=%h", a, got, e);
            else pass_cnt++;
            got = 64'(ifa.rd_busy);
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL clear_busy_zero a=%0d got=%h exp=%h", a, got, e);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_write_read();
        ifa.we      = 1'b1;
        ifa.wr_addr = 5'd5;
        ifa.wr_data = 32'hDEAD_BEEF;
        ifa.rd_addr = {5'd5, 5'd5};
        step();
        ifa.we = 1'b0;
        #1;
        exp_q.push_back(64'hDEAD_BEEF);
        exp_q.push_back(64'hDEAD_BEEF);
        for (int p = 0; p < 2; p++) begin
            got = 64'(ifa.rd_data[p*32 +: 32]);
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL rd_r5 port=%0d got=%h exp=%h", p, got, e);
            else pass_cnt++;
        end
        ifa.we      = 1'b1;
        ifa.wr_addr = 5'd0;
        ifa.wr_data = 32'h1234;
        ifa.rd_addr = {5'd0, 5'd0};
        step();
        ifa.we = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_data);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL rd_r0 got=%h exp=%h", got, e);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        ifa.we      = 1'b1;
        ifa.wr_addr = 5'd7;
        ifa.wr_data = 32'h11;
        step();
        ifa.wr_data = 32'h22;
        ifa.rd_addr = {5'd0, 5'd7};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_q.push_back(64'h22);
`else
        exp_q.push_back(64'h11);
`endif
        got = 64'(ifa.rd_data[31:0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL same_cycle_r7 got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        ifa.we = 1'b0;
        #1;
        exp_q.push_back(64'h22);
        got = 64'(ifa.rd_data[31:0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL next_cycle_r7 got=%h exp=%h", got, e);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        ifa.sb_set  = 1'b1;
        ifa.sb_addr = 5'd9;
        ifa.rd_addr = {5'd0, 5'd9};
        #1;
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_before_set got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        ifa.sb_set = 1'b0;
        #1;
        exp_q.push_back(64'd1);
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_set_r9 got=%h exp=%h", got, e);
        else pass_cnt++;
        ifa.we      = 1'b1;
        ifa.wr_addr = 5'd9;
        ifa.wr_data = 32'h99;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_q.push_back(64'd0);
`else
        exp_q.push_back(64'd1);
`endif
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_write_cycle got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        ifa.we = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_cleared got=%h exp=%h", got, e);
        else pass_cnt++;
        ifa.we      = 1'b1;
        ifa.sb_set  = 1'b1;
        ifa.sb_addr = 5'd9;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_q.push_back(64'd1);
`else
        exp_q.push_back(64'd0);
`endif
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_both_cycle got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        ifa.we     = 1'b0;
        ifa.sb_set = 1'b0;
        #1;
        exp_q.push_back(64'd1);
        got = 64'(ifa.rd_busy[0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_set_wins got=%h exp=%h", got, e);
        else pass_cnt++;
        ifa.sb_set  = 1'b1;
        ifa.sb_addr = 5'd0;
        step();
        ifa.sb_set  = 1'b0;
        ifa.rd_addr = {5'd9, 5'd0};
        #1;
        exp_q.push_back(64'b10);
        got = 64'(ifa.rd_busy);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL sb_r0_never got=%h exp=%h", got, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_restart();
        ifa.we      = 1'b1;
        ifa.wr_addr = 5'd3;
        ifa.wr_data = 32'h55;
        ifa.rd_addr = {5'd0, 5'd3};
        step();
        ifa.we = 1'b0;
        #1;
        exp_q.push_back(64'h55);
        got = 64'(ifa.rd_data[31:0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL r3_before_reset got=%h exp=%h", got, e);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        got = 64'(ifa.init_done) | 64'(ifa.rd_data);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL ready_reset_drop got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        rst_n = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        got = 64'(ifa.init_done);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL midclear_reset_drop got=%h exp=%h", got, e);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k >= 31) begin
                exp_q.push_back(64'(k == 32));
                got = 64'(ifa.init_done);
                e = exp_q.pop_front();
                tot_cnt++;
                if (got !== e) $display("FAIL rerun_init_done k=%0d got=%h exp=%h", k, got, e);
                else pass_cnt++;
            end
        end
        exp_q.push_back(64'd0);
        got = 64'(ifa.rd_data[31:0]);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL r3_after_reset got=%h exp=%h", got, e);
        else pass_cnt++;
    endtask

    task automatic test_multiport();
        logic [63:0] vals [5];
        int          amap [4];
        for (int r = 1; r <= 4; r++) begin
            vals[r] = 64'hA5A5_0000_0000_0000 ^ (64'(r) * 64'h0001_0203_0405_0607);
            ifb.we      = 1'b1;
            ifb.wr_addr = 4'(r);
            ifb.wr_data = vals[r];
            step();
        end
        ifb.we = 1'b0;
        amap[0] = 3;
        amap[1] = 1;
        amap[2] = 4;
        amap[3] = 2;
        ifb.rd_addr = {4'd2, 4'd4, 4'd1, 4'd3};
        for (int p = 0; p < 4; p++) exp_q.push_back(vals[amap[p]]);
        #1;
        for (int p = 0; p < 4; p++) begin
            got = ifb.rd_data[p*64 +: 64];
            e = exp_q.pop_front();
            tot_cnt++;
            if (got !== e) $display("FAIL multiport port=%0d got=%h exp=%h", p, got, e);
            else pass_cnt++;
        end
        exp_q.push_back(64'd0);
        got = 64'(ifb.rd_busy);
        e = exp_q.pop_front();
        tot_cnt++;
        if (got !== e) $display("FAIL multiport_busy got=%h exp=%h", got, e);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        tot_cnt     = 0;
        rst_n       = 1'b0;
        ifa.we      = 1'b0;
        ifa.wr_addr = '0;
        ifa.wr_data = '0;
        ifa.sb_set  = 1'b0;
        ifa.sb_addr = '0;
        ifa.rd_addr = '0;
        ifb.we      = 1'b0;
        ifb.wr_addr = '0;
        ifb.wr_data = '0;
        ifb.sb_set  = 1'b0;
        ifb.sb_addr = '0;
        ifb.rd_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_reset_restart();
        test_multiport();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
